// File: rtl/multicycle_control_pkg.sv
// Shared opcode, funct, state and control-code definitions for the multicycle controller.
package multicycle_control_pkg;

  localparam logic [5:0] OP_R      = 6'h00;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BLEZAL = 6'h16;
  localparam logic [5:0] OP_BALV   = 6'h1B;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] FN_BRV    = 6'h14;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_R_EXEC   = 4'd2,
    S_R_WB     = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WB   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_BEQ      = 4'd8,
    S_JUMP     = 4'd9,
    S_BLEZAL   = 4'd10,
    S_BALV     = 4'd11,
    S_BRV      = 4'd12
  } state_t;

  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_RS     = 2'd3;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;

  localparam logic [1:0] RD_RT     = 2'd0;
  localparam logic [1:0] RD_RD     = 2'd1;
  localparam logic [1:0] RD_RA     = 2'd2;

  localparam logic [1:0] ALUB_RT      = 2'd0;
  localparam logic [1:0] ALUB_FOUR    = 2'd1;
  localparam logic [1:0] ALUB_IMM     = 2'd2;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'd3;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // R-type functs the ALU can execute; brv is decoded separately.
  function automatic logic is_legal_r(input logic [5:0] fn);
    case (fn)
      6'h00, 6'h02, 6'h03, 6'h20, 6'h21, 6'h22, 6'h23,
      6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath signal bundle; master is the controller, slave the datapath.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       rs_lez;
  logic [2:0] stat;
  logic       mem_ready;
  logic       pc_we;
  logic [1:0] pc_src;
  logic       iord;
  logic       mem_re;
  logic       mem_we;
  logic       ir_we;
  logic       reg_we;
  logic [1:0] reg_dst;
  logic [1:0] wb_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       status_we;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, funct, zero, rs_lez, stat, mem_ready,
    output pc_we, pc_src, iord, mem_re, mem_we, ir_we, reg_we, reg_dst, wb_src,
           alu_src_a, alu_src_b, alu_op, status_we, illegal, state
  );

  modport slave (
    output opcode, funct, zero, rs_lez, stat, mem_ready,
    input  pc_we, pc_src, iord, mem_re, mem_we, ir_we, reg_we, reg_dst, wb_src,
           alu_src_a, alu_src_b, alu_op, status_we, illegal, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore sequencing FSM: fetch/decode/execute/memory/writeback over one memory port and one ALU.
//   state      | meaning
//   S_FETCH    | read instruction at PC, PC <= PC+4 when memory is ready
//   S_DECODE   | branch target into ALUOut, dispatch on opcode
//   S_R_EXEC   | rs op rt, load status flags
//   S_R_WB     | ALUOut -> rd
//   S_MEM_ADDR | rs + imm address
//   S_MEM_RD   | data read, wait for ready
//   S_MEM_WB   | MDR -> rt
//   S_MEM_WR   | data write, wait for ready
//   S_BEQ      | compare, branch on zero
//   S_JUMP     | PC <= jump target
//   S_BLEZAL   | branch-and-link when rs <= 0
//   S_BALV     | jump-and-link on overflow flag
//   S_BRV      | jump-register-and-link on overflow flag
module multicycle_control
  import multicycle_control_pkg::*;
(
  input logic clk,
  input logic rst,
  multicycle_control_if.master ctl
);

  state_t state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    ctl.pc_we     = 1'b0;
    ctl.pc_src    = PC_ALU;
    ctl.iord      = 1'b0;
    ctl.mem_re    = 1'b0;
    ctl.mem_we    = 1'b0;
    ctl.ir_we     = 1'b0;
    ctl.reg_we    = 1'b0;
    ctl.reg_dst   = RD_RT;
    ctl.wb_src    = WB_ALUOUT;
    ctl.alu_src_a = 1'b0;
    ctl.alu_src_b = ALUB_RT;
    ctl.alu_op    = ALU_ADD;
    ctl.status_we = 1'b0;
    ctl.illegal   = 1'b0;
    ctl.state     = state_q;

    case (state_q)
      S_FETCH: begin
        ctl.mem_re    = 1'b1;
        ctl.alu_src_b = ALUB_FOUR;
        ctl.ir_we     = ctl.mem_ready;
        ctl.pc_we     = ctl.mem_ready;
        if (ctl.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ctl.alu_src_b = ALUB_IMM_SH2;
        state_d       = S_FETCH;
        case (ctl.opcode)
          OP_R: begin
            if (ctl.funct == FN_BRV)         state_d = S_BRV;
            else if (is_legal_r(ctl.funct))  state_d = S_R_EXEC;
            else                             ctl.illegal = 1'b1;
          end
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BEQ;
          OP_J:         state_d = S_JUMP;
          OP_BLEZAL:    state_d = S_BLEZAL;
          OP_BALV:      state_d = S_BALV;
          default:      ctl.illegal = 1'b1;
        endcase
      end
      S_R_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_op    = ALU_FUNCT;
        ctl.status_we = 1'b1;
        state_d       = S_R_WB;
      end
      S_R_WB: begin
        ctl.reg_we  = 1'b1;
        ctl.reg_dst = RD_RD;
        state_d     = S_FETCH;
      end
      S_MEM_ADDR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = ALUB_IMM;
        state_d       = (ctl.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        ctl.iord   = 1'b1;
        ctl.mem_re = 1'b1;
        if (ctl.mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        ctl.reg_we = 1'b1;
        ctl.wb_src = WB_MDR;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        ctl.iord   = 1'b1;
        ctl.mem_we = 1'b1;
        if (ctl.mem_ready) state_d = S_FETCH;
      end
      S_BEQ: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_op    = ALU_SUB;
        ctl.pc_src    = PC_ALUOUT;
        ctl.pc_we     = ctl.zero;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        ctl.pc_src = PC_JUMP;
        ctl.pc_we  = 1'b1;
        state_d    = S_FETCH;
      end
      S_BLEZAL: begin
        ctl.pc_src  = PC_ALUOUT;
        ctl.reg_dst = RD_RA;
        ctl.wb_src  = WB_PC;
        ctl.pc_we   = ctl.rs_lez;
        ctl.reg_we  = ctl.rs_lez;
        state_d     = S_FETCH;
      end
      S_BALV, S_BRV: begin
        ctl.pc_src  = (state_q == S_BRV) ? PC_RS : PC_JUMP;
        ctl.reg_dst = RD_RA;
        ctl.wb_src  = WB_PC;
        ctl.pc_we   = ctl.stat[0];
        ctl.reg_we  = ctl.stat[0];
        state_d     = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset must silence every strobe immediately, not on the next edge.
    if (rst) begin
      ctl.pc_we     = 1'b0;
      ctl.ir_we     = 1'b0;
      ctl.reg_we    = 1'b0;
      ctl.mem_re    = 1'b0;
      ctl.mem_we    = 1'b0;
      ctl.status_we = 1'b0;
      ctl.illegal   = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: per-instruction effect totals compared against an instruction-level model.
module tb_multicycle_control;

  localparam logic [5:0] T_R = 6'h00, T_J = 6'h02, T_BEQ = 6'h04, T_BLEZAL = 6'h16;
  localparam logic [5:0] T_BALV = 6'h1B, T_LW = 6'h23, T_SW = 6'h2B, T_BRV = 6'h14;

  typedef struct {
    int cycles;
    int pc_we_n;
    int ir_we_n;
    int reg_we_n;
    int mem_re_n;
    int mem_we_n;
    int status_we_n;
    int illegal_n;
    logic [1:0] pc_src_last;
    logic [1:0] reg_dst_wr;
    logic [1:0] wb_src_wr;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;

  multicycle_control_if bus();
  multicycle_control dut (.clk(clk), .rst(rst), .ctl(bus.master));

  always #5 clk = ~clk;

  function automatic bit legal_funct(input logic [5:0] fn);
    logic [5:0] ok [13] = '{6'h00, 6'h02, 6'h03, 6'h20, 6'h21, 6'h22, 6'h23,
                            6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    foreach (ok[i]) if (ok[i] == fn) return 1'b1;
    return 1'b0;
  endfunction

  function automatic obs_t take_branch(input obs_t e, input bit cond, input logic [1:0] src,
                                       input bit link);
    obs_t r = e;
    r.cycles = r.cycles + 1;
    if (cond) begin
      r.pc_we_n = r.pc_we_n + 1;
      r.pc_src_last = src;
      if (link) begin
        r.reg_we_n = 1;
        r.reg_dst_wr = 2'd2;
        r.wb_src_wr = 2'd2;
      end
    end
    return r;
  endfunction

  // Instruction-level expectation: cycle count and how often each effect fires.
  function automatic obs_t model(input logic [5:0] op, input logic [5:0] fn, input logic z,
                                 input logic lez, input logic [2:0] st, input int sf, input int sm);
    obs_t e = '{default: 0};
    e.cycles = 2 + sf;
    e.ir_we_n = 1;
    e.pc_we_n = 1;
    e.mem_re_n = 1 + sf;
    if (op == T_R && fn == T_BRV) e = take_branch(e, st[0], 2'd3, 1'b1);
    else if (op == T_R && legal_funct(fn)) begin
      e.cycles += 2; e.reg_we_n = 1; e.reg_dst_wr = 2'd1; e.wb_src_wr = 2'd0; e.status_we_n = 1;
    end else if (op == T_LW) begin
      e.cycles += 3 + sm; e.mem_re_n += 1 + sm; e.reg_we_n = 1; e.reg_dst_wr = 2'd0;
      e.wb_src_wr = 2'd1;
    end else if (op == T_SW) begin
      e.cycles += 2 + sm; e.mem_we_n = 1 + sm;
    end
    else if (op == T_BEQ)    e = take_branch(e, z, 2'd1, 1'b0);
    else if (op == T_J)      e = take_branch(e, 1'b1, 2'd2, 1'b0);
    else if (op == T_BLEZAL) e = take_branch(e, lez, 2'd1, 1'b1);
    else if (op == T_BALV)   e = take_branch(e, st[0], 2'd2, 1'b1);
    else e.illegal_n = 1;
    return e;
  endfunction

  // Runs one instruction from S_FETCH back to S_FETCH; memory stalls sf (fetch) / sm (data) cycles.
  task automatic drive_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input logic lez, input logic [2:0] st, input int sf, input int sm,
                             output obs_t o);
    int access = 0;
    int rem = 0;
    bit in_acc = 0;
    bit left = 0;
    o = '{default: 0};
    bus.opcode = op; bus.funct = fn; bus.zero = z; bus.rs_lez = lez; bus.stat = st;
    for (int c = 0; c < 40; c++) begin
      if (bus.mem_re || bus.mem_we) begin
        if (!in_acc) begin
          in_acc = 1; rem = (access == 0) ? sf : sm; access++;
        end
        if (rem > 0) begin bus.mem_ready = 1'b0; rem--; end
        else begin bus.mem_ready = 1'b1; in_acc = 0; end
      end else begin
        bus.mem_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      o.cycles++;
      if (bus.pc_we) begin o.pc_we_n++; o.pc_src_last = bus.pc_src; end
      if (bus.reg_we) begin o.reg_we_n++; o.reg_dst_wr = bus.reg_dst; o.wb_src_wr = bus.wb_src; end
      if (bus.ir_we) o.ir_we_n++;
      if (bus.mem_re) o.mem_re_n++;
      if (bus.mem_we) o.mem_we_n++;
      if (bus.status_we) o.status_we_n++;
      if (bus.illegal) o.illegal_n++;
      @(posedge clk); #1;
      if (bus.state != 4'd0) left = 1;
      else if (left) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.mem_ready = 1'b1; bus.opcode = T_R; bus.funct = 6'h20;
    bus.zero = 1'b1; bus.rs_lez = 1'b1; bus.stat = 3'b111;
    #12;
    checks++;
    if (bus.state !== 4'd0) begin errors++; $display("FAIL reset_state got %0d want 0", bus.state); end
    checks++;
    if ({bus.pc_we, bus.ir_we, bus.reg_we, bus.mem_re, bus.mem_we, bus.status_we, bus.illegal} !== 7'b0) begin
      errors++;
      $display("FAIL reset_strobes got %b want 0000000",
               {bus.pc_we, bus.ir_we, bus.reg_we, bus.mem_re, bus.mem_we, bus.status_we, bus.illegal});
    end
    bus.mem_ready = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.state !== 4'd0 || bus.mem_re !== 1'b1) begin
      errors++; $display("FAIL reset_release got state %0d mem_re %b want 0 1", bus.state, bus.mem_re);
    end
  endtask

  task automatic test_lw_stall();
    obs_t o;
    drive_instr(T_LW, 6'h00, 1'b0, 1'b0, 3'b000, 0, 2, o);
    checks++;
    if (o.cycles !== 7) begin errors++; $display("FAIL lw_cycles got %0d want 7", o.cycles); end
    checks++;
    if (o.reg_we_n !== 1 || o.reg_dst_wr !== 2'd0 || o.wb_src_wr !== 2'd1) begin
      errors++; $display("FAIL lw_writeback got n=%0d dst=%0d wb=%0d want 1 0 1",
                         o.reg_we_n, o.reg_dst_wr, o.wb_src_wr);
    end
    checks++;
    if (o.mem_re_n !== 4) begin errors++; $display("FAIL lw_mem_re got %0d want 4", o.mem_re_n); end
  endtask

  task automatic test_beq();
    obs_t o;
    for (int z = 1; z >= 0; z--) begin
      drive_instr(T_BEQ, 6'h00, 1'(z), 1'b0, 3'b000, 0, 0, o);
      checks++;
      if (o.cycles !== 3) begin errors++; $display("FAIL beq_cycles z=%0d got %0d want 3", z, o.cycles); end
      checks++;
      if (o.pc_we_n !== 1 + z || o.pc_src_last !== (z ? 2'd1 : 2'd0)) begin
        errors++; $display("FAIL beq_pc z=%0d got n=%0d src=%0d want %0d %0d",
                           z, o.pc_we_n, o.pc_src_last, 1 + z, z);
      end
    end
  endtask

  task automatic test_blezal();
    obs_t o;
    for (int l = 1; l >= 0; l--) begin
      drive_instr(T_BLEZAL, 6'h00, 1'b0, 1'(l), 3'b000, 1, 0, o);
      checks++;
      if (o.pc_we_n !== 1 + l || o.reg_we_n !== l) begin
        errors++; $display("FAIL blezal_we lez=%0d got pc=%0d reg=%0d want %0d %0d",
                           l, o.pc_we_n, o.reg_we_n, 1 + l, l);
      end
      if (l == 1) begin
        checks++;
        if (o.reg_dst_wr !== 2'd2 || o.wb_src_wr !== 2'd2 || o.pc_src_last !== 2'd1) begin
          errors++; $display("FAIL blezal_link got dst=%0d wb=%0d src=%0d want 2 2 1",
                             o.reg_dst_wr, o.wb_src_wr, o.pc_src_last);
        end
      end
    end
  endtask

  task automatic test_balv_brv();
    obs_t o, e;
    logic [2:0] sts [2] = '{3'b001, 3'b100};
    for (int k = 0; k < 2; k++) begin
      foreach (sts[s]) begin
        if (k == 0) drive_instr(T_BALV, 6'h00, 1'b0, 1'b0, sts[s], 0, 0, o);
        else        drive_instr(T_R, T_BRV, 1'b0, 1'b0, sts[s], 0, 0, o);
        e = model(k == 0 ? T_BALV : T_R, k == 0 ? 6'h00 : T_BRV, 1'b0, 1'b0, sts[s], 0, 0);
        checks++;
        if (o.pc_we_n !== e.pc_we_n || o.pc_src_last !== e.pc_src_last || o.reg_we_n !== e.reg_we_n
            || o.reg_dst_wr !== e.reg_dst_wr || o.cycles !== e.cycles) begin
          errors++; $display("FAIL link_jump k=%0d stat=%b got pc=%0d src=%0d reg=%0d dst=%0d cyc=%0d want %0d %0d %0d %0d %0d",
                             k, sts[s], o.pc_we_n, o.pc_src_last, o.reg_we_n, o.reg_dst_wr, o.cycles,
                             e.pc_we_n, e.pc_src_last, e.reg_we_n, e.reg_dst_wr, e.cycles);
        end
      end
    end
  endtask

  task automatic test_illegal();
    obs_t o;
    drive_instr(6'h3F, 6'h00, 1'b1, 1'b1, 3'b111, 0, 0, o);
    checks++;
    if (o.illegal_n !== 1 || o.cycles !== 2) begin
      errors++; $display("FAIL illegal_pulse got n=%0d cyc=%0d want 1 2", o.illegal_n, o.cycles);
    end
    checks++;
    if (o.reg_we_n !== 0 || o.mem_we_n !== 0 || o.status_we_n !== 0 || o.pc_we_n !== 1) begin
      errors++; $display("FAIL illegal_writes got reg=%0d mem=%0d st=%0d pc=%0d want 0 0 0 1",
                         o.reg_we_n, o.mem_we_n, o.status_we_n, o.pc_we_n);
    end
  endtask

  task automatic test_reset_mid_write();
    bus.opcode = T_SW; bus.funct = 6'h00; bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL mid_write_setup got mem_we %b want 1", bus.mem_we); end
    bus.mem_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.state !== 4'd0 || bus.mem_we !== 1'b0 || bus.pc_we !== 1'b0 || bus.mem_re !== 1'b0) begin
      errors++; $display("FAIL async_reset got state %0d mem_we %b pc_we %b mem_re %b want 0 0 0 0",
                         bus.state, bus.mem_we, bus.pc_we, bus.mem_re);
    end
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.state !== 4'd1) begin errors++; $display("FAIL fetch_resume got state %0d want 1", bus.state); end
    bus.opcode = T_J;
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (bus.state !== 4'd0) begin errors++; $display("FAIL post_reset_jump got state %0d want 0", bus.state); end
  endtask

  task automatic test_random();
    obs_t o, e;
    logic [5:0] rfn [13] = '{6'h00, 6'h02, 6'h03, 6'h20, 6'h21, 6'h22, 6'h23,
                             6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    logic [5:0] ops [7] = '{T_J, T_BEQ, T_BLEZAL, T_BALV, T_LW, T_SW, 6'h3F};
    logic [5:0] op, fn;
    logic z, lez;
    logic [2:0] st;
    int sf, sm;
    for (int n = 0; n < 60; n++) begin
      fn = 6'($urandom_range(0, 63));
      case ($urandom_range(0, 3))
        0: op = T_R;
        1: begin op = T_R; fn = rfn[$urandom_range(0, 12)]; end
        2: begin op = T_R; fn = T_BRV; end
        default: op = ops[$urandom_range(0, 6)];
      endcase
      if ($urandom_range(0, 9) == 0) op = 6'($urandom_range(0, 63));
      z = 1'($urandom_range(0, 1)); lez = 1'($urandom_range(0, 1));
      st = 3'($urandom_range(0, 7));
      sf = $urandom_range(0, 2); sm = $urandom_range(0, 2);
      drive_instr(op, fn, z, lez, st, sf, sm, o);
      e = model(op, fn, z, lez, st, sf, sm);
      checks++;
      if (o.cycles !== e.cycles) begin
        errors++; $display("FAIL rand_cycles op=%h fn=%h got %0d want %0d", op, fn, o.cycles, e.cycles);
      end
      checks++;
      if (o.pc_we_n !== e.pc_we_n || o.pc_src_last !== e.pc_src_last || o.ir_we_n !== e.ir_we_n) begin
        errors++; $display("FAIL rand_pc op=%h fn=%h got %0d/%0d/%0d want %0d/%0d/%0d", op, fn,
                           o.pc_we_n, o.pc_src_last, o.ir_we_n, e.pc_we_n, e.pc_src_last, e.ir_we_n);
      end
      checks++;
      if (o.reg_we_n !== e.reg_we_n || o.reg_dst_wr !== e.reg_dst_wr || o.wb_src_wr !== e.wb_src_wr) begin
        errors++; $display("FAIL rand_reg op=%h fn=%h got %0d/%0d/%0d want %0d/%0d/%0d", op, fn,
                           o.reg_we_n, o.reg_dst_wr, o.wb_src_wr, e.reg_we_n, e.reg_dst_wr, e.wb_src_wr);
      end
      checks++;
      if (o.mem_re_n !== e.mem_re_n || o.mem_we_n !== e.mem_we_n || o.status_we_n !== e.status_we_n
          || o.illegal_n !== e.illegal_n) begin
        errors++; $display("FAIL rand_misc op=%h fn=%h got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", op, fn,
                           o.mem_re_n, o.mem_we_n, o.status_we_n, o.illegal_n,
                           e.mem_re_n, e.mem_we_n, e.status_we_n, e.illegal_n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw_stall();
    test_beq();
    test_blezal();
    test_balv_brv();
    test_illegal();
    test_reset_mid_write();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
